branch_window_ctrl: RTL and testbench
=====================================

Name: branch_window_ctrl

Overview:
Parametrised fetch-group branch handler that sits between the I-cache fetch group and the decode/dataout stage.
- Classifies every slot as conditional branch, immediate jump or register jump.
- Truncates the group at the first control transfer or at the in-flight branch cap, and nulls the dropped slots to 16'h0 NOP encoding.
- Tracks unresolved branches with a saturating counter (commit decrements, mispredict restores).
- Holds fetch for register jumps until the target arrives, and drives PC hold/refetch selection to the PC mux.

Parameters:
FETCH_W, 4, slots per fetch group; slot 0 is the oldest.
INST_W, 16, instruction width.
PC_W, 16, PC width.
MAX_BR, 2, maximum unresolved branches in flight (>=1).
CNT_W, $clog2(MAX_BR+1), counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pc  in  PC_W  PC of slot 0
inst_grp  in  FETCH_W*INST_W  fetch group; slot i at [i*INST_W +: INST_W]
pred_taken  in  FETCH_W  predictor taken bit per slot; ignored on non-branch slots
stall_fetch  in  1  external fetch stall
commit_br_cnt  in  CNT_W  branches retired this cycle (from ROB)
mispredict  in  1  branch mispredict squash
mispred_keep  in  CNT_W  surviving in-flight branches after the squash
jmp_tgt_valid  in  1  register-jump target ready
jmp_tgt  in  PC_W  register-jump target
inst_out  out  FETCH_W*INST_W  group with dropped slots zeroed
slot_valid  out  FETCH_W  slot survives
tkn_brnch  out  FETCH_W  surviving branch predicted taken
is_im_jmp  out  FETCH_W  surviving immediate jump
update_bpred  out  1  at least one surviving branch
pcsel_from_bhndlr  out  1  PC mux takes pc_bhndlr
pc_bhndlr  out  PC_W  hold/refetch/jump-target PC
brch_full  out  1  counter at MAX_BR
wait_jmp  out  1  FSM in WAIT_JMP
flush_mem  out  1  registered flush pulse
br_cnt  out  CNT_W  in-flight branch count

Behaviour:
Decode per slot:
- jump: op[15:12]==4'hF.
- immediate jump: jump with inst[1:0]==0.
- register jump: jump with inst[1:0]!=0.
- branch: op[15:14]==2'b10 and op[13:12]!=2'b00.

Admission, only in RUN with stall_fetch low. Slots are scanned oldest first; slot i survives if all of the following hold:
- no earlier slot was a jump;
- no earlier surviving branch has pred_taken set;
- br_cnt plus the earlier surviving branches is < MAX_BR when slot i is itself a branch.
- Admission uses registered br_cnt only; same-cycle commits do not free room.

Truncation and PC selection:
- Cap truncation at slot k: pcsel=1, pc_bhndlr=pc+k (refetch).
- Jump or taken branch: pcsel=0; the target comes from the branch address calculator.
- Register jump: also moves the FSM to WAIT_JMP.

FSM (RUN, WAIT_JMP, FLUSH):
- RUN:
  - stall_fetch: all slots dropped, pcsel=1, pc_bhndlr=pc.
  - br_cnt==MAX_BR: brch_full=1; group dropped and pc held the same way.
- WAIT_JMP: group dropped, pcsel=1, pc_bhndlr=pc. When jmp_tgt_valid=1, pc_bhndlr=jmp_tgt that cycle and next state is RUN.
- FLUSH: entered from any state on mispredict; lasts exactly 1 cycle; group dropped, pcsel=0; returns to RUN.
- mispredict in WAIT_JMP abandons the wait.

Counter:
- next = br_cnt - commit_br_cnt + admitted_branches.
- Decrement saturates at 0; result clamps to MAX_BR.
- mispredict overrides: br_cnt <= min(mispred_keep, MAX_BR); commit that cycle is ignored.

flush_mem: registered to 1 when the previous cycle had mispredict or any admitted taken branch/jump.

Reset (rst high at clk edge), applied even mid-WAIT_JMP or mid-FLUSH:
- state=RUN, br_cnt=0, flush_mem=0.
- Combinational outputs then follow RUN rules.

Decomposition:
- Shared package br_pkg:
  - opcode constants OP_JMP=4'hF and BR_PFX=2'b10;
  - state enum {RUN, WAIT_JMP, FLUSH};
  - slot-class typedef.
- One sub-module br_slot_decode, instantiated FETCH_W times. It is purely combinational and outputs is_br, is_imjmp and is_regjmp per slot.

Test Plan:
- FETCH_W=4, MAX_BR=2, br_cnt=0; group [add, br(pred 0), add, br(pred 0)] -> slot_valid=4'b1111, update_bpred=1, br_cnt=2 next cycle, brch_full=1.
- br_cnt=1; group [br, br, add, add], no taken predictions -> slot_valid=4'b0001, pcsel=1, pc_bhndlr=pc+1, br_cnt becomes 2.
- Slot1 is a register jump (inst[1:0]=2'b01) -> slot_valid=4'b0011, wait_jmp next cycle; hold pc for 3 cycles; jmp_tgt_valid=1 with jmp_tgt=16'h0200 -> pc_bhndlr=16'h0200, RUN next cycle.
- Slot0 branch with pred_taken=1 -> slot_valid=4'b0001, tkn_brnch=4'b0001, pcsel=0, flush_mem=1 one cycle later.
- br_cnt=2, commit_br_cnt=1 and mispredict=1 with mispred_keep=0 in the same cycle -> br_cnt=0, FLUSH for 1 cycle with all slots dropped, then RUN.
- rst asserted while in WAIT_JMP with br_cnt=2 -> next cycle state=RUN, br_cnt=0, flush_mem=0, wait_jmp=0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared opcode constants, FSM states and slot classification for the
// fetch-group branch handler.
package br_pkg;

  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [1:0] BR_PFX = 2'b10;

  typedef enum logic [1:0] {RUN, WAIT_JMP, FLUSH} state_e;

  typedef enum logic [1:0] {SC_OTHER, SC_BR, SC_IMJMP, SC_REGJMP} slot_class_e;

  // Jump and branch opcode spaces are disjoint, so the checks can be ordered freely.
  function automatic slot_class_e classify(input logic [3:0] op, input logic [1:0] lo);
    slot_class_e cls;
    cls = SC_OTHER;
    if (op == OP_JMP) begin
      if (lo == 2'b00) cls = SC_IMJMP;
      else             cls = SC_REGJMP;
    end else if (op[3:2] == BR_PFX && op[1:0] != 2'b00) begin
      cls = SC_BR;
    end
    return cls;
  endfunction

endpackage

// File: rtl/br_slot_decode.sv
// Per-slot control-transfer decode: only the opcode nibble and the two low
// bits of the instruction matter.
module br_slot_decode
  import br_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] lo,
  output logic       is_br,
  output logic       is_imjmp,
  output logic       is_regjmp
);

  slot_class_e cls;

  always_comb begin
    cls       = classify(op, lo);
    is_br     = (cls == SC_BR);
    is_imjmp  = (cls == SC_IMJMP);
    is_regjmp = (cls == SC_REGJMP);
  end

endmodule

// File: rtl/branch_window_ctrl.sv
// Fetch-group branch handler: truncates the group at the first control
// transfer or the in-flight branch cap, tracks unresolved branches, drives PC hold/refetch.
module branch_window_ctrl
  import br_pkg::*;
#(
  parameter int FETCH_W = 4,
  parameter int INST_W  = 16,
  parameter int PC_W    = 16,
  parameter int MAX_BR  = 2,
  parameter int CNT_W   = $clog2(MAX_BR + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PC_W-1:0]             pc,
  input  logic [FETCH_W*INST_W-1:0]   inst_grp,
  input  logic [FETCH_W-1:0]          pred_taken,
  input  logic                        stall_fetch,
  input  logic [CNT_W-1:0]            commit_br_cnt,
  input  logic                        mispredict,
  input  logic [CNT_W-1:0]            mispred_keep,
  input  logic                        jmp_tgt_valid,
  input  logic [PC_W-1:0]             jmp_tgt,
  output logic [FETCH_W*INST_W-1:0]   inst_out,
  output logic [FETCH_W-1:0]          slot_valid,
  output logic [FETCH_W-1:0]          tkn_brnch,
  output logic [FETCH_W-1:0]          is_im_jmp,
  output logic                        update_bpred,
  output logic                        pcsel_from_bhndlr,
  output logic [PC_W-1:0]             pc_bhndlr,
  output logic                        brch_full,
  output logic                        wait_jmp,
  output logic                        flush_mem,
  output logic [CNT_W-1:0]            br_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic             flush_q, flush_d;

  logic [FETCH_W-1:0] dec_br, dec_imjmp, dec_regjmp;

  logic alive;
  logic xfer;
  logic regjmp_hit;
  int   n_adm;
  int   cnt_i;

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
    br_slot_decode u_dec (
      .op        (inst_grp[gi*INST_W + INST_W - 4 +: 4]),
      .lo        (inst_grp[gi*INST_W +: 2]),
      .is_br     (dec_br[gi]),
      .is_imjmp  (dec_imjmp[gi]),
      .is_regjmp (dec_regjmp[gi])
    );
    assign inst_out[gi*INST_W +: INST_W] =
      slot_valid[gi] ? inst_grp[gi*INST_W +: INST_W] : '0;
  end

  assign brch_full = (int'(br_cnt_q) == MAX_BR);
  assign wait_jmp  = (state_q == WAIT_JMP);
  assign flush_mem = flush_q;
  assign br_cnt    = br_cnt_q;

  always_comb begin
    state_d           = state_q;
    slot_valid        = '0;
    tkn_brnch         = '0;
    is_im_jmp         = '0;
    pcsel_from_bhndlr = 1'b0;
    pc_bhndlr         = pc;
    alive             = 1'b0;
    xfer              = 1'b0;
    regjmp_hit        = 1'b0;
    n_adm             = 0;

    case (state_q)
      RUN: begin
        if (stall_fetch || brch_full) begin
          pcsel_from_bhndlr = 1'b1;
        end else begin
          alive = 1'b1;
          // Oldest-first scan; once a slot is refused every younger slot goes too.
          for (int i = 0; i < FETCH_W; i++) begin
            if (alive) begin
              if (dec_br[i] && (int'(br_cnt_q) + n_adm >= MAX_BR)) begin
                alive             = 1'b0;
                pcsel_from_bhndlr = 1'b1;
                pc_bhndlr         = pc + PC_W'(i);
              end else begin
                slot_valid[i] = 1'b1;
                if (dec_br[i]) begin
                  n_adm = n_adm + 1;
                  if (pred_taken[i]) begin
                    tkn_brnch[i] = 1'b1;
                    alive        = 1'b0;
                    xfer         = 1'b1;
                  end
                end
                if (dec_imjmp[i]) begin
                  is_im_jmp[i] = 1'b1;
                  alive        = 1'b0;
                  xfer         = 1'b1;
                end
                if (dec_regjmp[i]) begin
                  alive      = 1'b0;
                  xfer       = 1'b1;
                  regjmp_hit = 1'b1;
                end
              end
            end
          end
        end
        if (regjmp_hit) state_d = WAIT_JMP;
      end
      WAIT_JMP: begin
        pcsel_from_bhndlr = 1'b1;
        if (jmp_tgt_valid) begin
          pc_bhndlr = jmp_tgt;
          state_d   = RUN;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (mispredict) state_d = FLUSH;

    update_bpred = (n_adm != 0);

    if (mispredict) begin
      cnt_i = (int'(mispred_keep) > MAX_BR) ? MAX_BR : int'(mispred_keep);
    end else begin
      cnt_i = int'(br_cnt_q) - int'(commit_br_cnt);
      if (cnt_i < 0) cnt_i = 0;
      cnt_i = cnt_i + n_adm;
      if (cnt_i > MAX_BR) cnt_i = MAX_BR;
    end
    br_cnt_d = CNT_W'(cnt_i);

    flush_d = mispredict | xfer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      br_cnt_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
      flush_q  <= flush_d;
    end
  end

endmodule

// File: tb/tb_branch_window_ctrl.sv
// Self-checking bench for branch_window_ctrl: directed scenarios followed by
// random traffic, all checked against a behavioural model of the handler.
module tb_branch_window_ctrl;

  localparam int FW = 4;
  localparam int IW = 16;
  localparam int PW = 16;
  localparam int MB = 2;
  localparam int CW = 2;

  localparam logic [15:0] ADD  = 16'h1234;
  localparam logic [15:0] BR   = 16'h9004;
  localparam logic [15:0] REGJ = 16'hF001;
  localparam logic [15:0] IMJ  = 16'hF010;

  logic             clk = 1'b0;
  logic             rst;
  logic [PW-1:0]    pc;
  logic [FW*IW-1:0] inst_grp;
  logic [FW-1:0]    pred_taken;
  logic             stall_fetch;
  logic [CW-1:0]    commit_br_cnt;
  logic             mispredict;
  logic [CW-1:0]    mispred_keep;
  logic             jmp_tgt_valid;
  logic [PW-1:0]    jmp_tgt;
  logic [FW*IW-1:0] inst_out;
  logic [FW-1:0]    slot_valid;
  logic [FW-1:0]    tkn_brnch;
  logic [FW-1:0]    is_im_jmp;
  logic             update_bpred;
  logic             pcsel_from_bhndlr;
  logic [PW-1:0]    pc_bhndlr;
  logic             brch_full;
  logic             wait_jmp;
  logic             flush_mem;
  logic [CW-1:0]    br_cnt;

  always #5 clk = ~clk;

  branch_window_ctrl #(
    .FETCH_W(FW), .INST_W(IW), .PC_W(PW), .MAX_BR(MB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_grp(inst_grp), .pred_taken(pred_taken),
    .stall_fetch(stall_fetch), .commit_br_cnt(commit_br_cnt), .mispredict(mispredict),
    .mispred_keep(mispred_keep), .jmp_tgt_valid(jmp_tgt_valid), .jmp_tgt(jmp_tgt),
    .inst_out(inst_out), .slot_valid(slot_valid), .tkn_brnch(tkn_brnch),
    .is_im_jmp(is_im_jmp), .update_bpred(update_bpred),
    .pcsel_from_bhndlr(pcsel_from_bhndlr), .pc_bhndlr(pc_bhndlr),
    .brch_full(brch_full), .wait_jmp(wait_jmp), .flush_mem(flush_mem), .br_cnt(br_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: mode 0 = running, 1 = waiting for register-jump target, 2 = flushing.
  int   m_mode, m_cnt;
  bit   m_flush;
  int   n_mode, n_cnt;
  bit   n_flush;
  logic [FW*IW-1:0] e_inst;
  logic [FW-1:0]    e_valid, e_tkn, e_imj;
  logic             e_upd, e_pcsel;
  logic [PW-1:0]    e_pc;

  function automatic int cls_of(input logic [15:0] w);
    if (w[15:12] == 4'hF) return (w[1:0] == 2'b00) ? 2 : 3;
    if (w[15:14] == 2'b10 && w[13:12] != 2'b00) return 1;
    return 0;
  endfunction

  function automatic logic [FW*IW-1:0] grp4(input logic [15:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic model_eval();
    int  adm_br;
    bit  stop, xfer, to_wait;
    int  c;
    logic [15:0] w;
    e_valid = '0; e_tkn = '0; e_imj = '0; e_pcsel = 1'b0; e_pc = pc;
    adm_br = 0; xfer = 0; to_wait = 0;
    if (m_mode == 0) begin
      if (stall_fetch || m_cnt == MB) begin
        e_pcsel = 1'b1;
      end else begin
        stop = 0;
        for (int i = 0; i < FW; i++) begin
          if (!stop) begin
            w = inst_grp[i*IW +: IW];
            c = cls_of(w);
            if (c == 1 && m_cnt + adm_br >= MB) begin
              stop = 1; e_pcsel = 1'b1; e_pc = pc + PW'(i);
            end else begin
              e_valid[i] = 1'b1;
              if (c == 1) begin
                adm_br++;
                if (pred_taken[i]) begin e_tkn[i] = 1'b1; stop = 1; xfer = 1; end
              end else if (c == 2) begin
                e_imj[i] = 1'b1; stop = 1; xfer = 1;
              end else if (c == 3) begin
                stop = 1; xfer = 1; to_wait = 1;
              end
            end
          end
        end
      end
    end else if (m_mode == 1) begin
      e_pcsel = 1'b1;
      if (jmp_tgt_valid) e_pc = jmp_tgt;
    end
    e_upd = (adm_br > 0);
    for (int i = 0; i < FW; i++)
      e_inst[i*IW +: IW] = e_valid[i] ? inst_grp[i*IW +: IW] : 16'h0000;

    if (rst) begin
      n_mode = 0; n_cnt = 0; n_flush = 0;
    end else begin
      if (mispredict)            n_mode = 2;
      else if (m_mode == 2)      n_mode = 0;
      else if (m_mode == 1)      n_mode = jmp_tgt_valid ? 0 : 1;
      else                       n_mode = to_wait ? 1 : 0;
      if (mispredict) begin
        n_cnt = (int'(mispred_keep) < MB) ? int'(mispred_keep) : MB;
      end else begin
        n_cnt = m_cnt - int'(commit_br_cnt);
        if (n_cnt < 0) n_cnt = 0;
        n_cnt += adm_br;
        if (n_cnt > MB) n_cnt = MB;
      end
      n_flush = mispredict | xfer;
    end
  endtask

  task automatic apply(input logic r, input logic [PW-1:0] p, input logic [FW*IW-1:0] g,
                       input logic [FW-1:0] pt, input logic st, input logic [CW-1:0] cm,
                       input logic mp, input logic [CW-1:0] mk, input logic jv,
                       input logic [PW-1:0] jt);
    @(negedge clk);
    rst = r; pc = p; inst_grp = g; pred_taken = pt; stall_fetch = st;
    commit_br_cnt = cm; mispredict = mp; mispred_keep = mk;
    jmp_tgt_valid = jv; jmp_tgt = jt;
    #1;
    model_eval();
    chk("inst_out",  inst_out, e_inst);
    chk("slot_valid", slot_valid, e_valid);
    chk("tkn_brnch", tkn_brnch, e_tkn);
    chk("is_im_jmp", is_im_jmp, e_imj);
    chk("update_bpred", update_bpred, e_upd);
    chk("pcsel", pcsel_from_bhndlr, e_pcsel);
    if (e_pcsel) chk("pc_bhndlr", pc_bhndlr, e_pc);
    chk("brch_full", brch_full, (m_cnt == MB));
    chk("wait_jmp", wait_jmp, (m_mode == 1));
    chk("flush_mem", flush_mem, m_flush);
    chk("br_cnt", br_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    m_mode = n_mode; m_cnt = n_cnt; m_flush = n_flush;
  endtask

  task automatic idle(input logic [CW-1:0] cm, input logic mp, input logic [CW-1:0] mk,
                      input logic jv, input logic [PW-1:0] jt, input logic r);
    apply(r, 16'h0100, grp4(ADD, ADD, ADD, ADD), 4'b0000, 1'b0, cm, mp, mk, jv, jt);
  endtask

  function automatic logic [15:0] rand_inst();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: return {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
      3:       return {4'h8, 12'($urandom)};
      4, 5:    return {2'b10, 2'($urandom_range(1, 3)), 12'($urandom)};
      6:       return {4'h9 + 4'($urandom_range(0, 2)), 12'($urandom)};
      7:       return {4'hF, 10'($urandom), 2'b00};
      8:       return {4'hF, 10'($urandom), 2'($urandom_range(1, 3))};
      default: return {4'hC + 4'($urandom_range(0, 2)), 12'($urandom)};
    endcase
  endfunction

  initial begin
    rst = 1'b1; pc = '0; inst_grp = '0; pred_taken = '0; stall_fetch = 1'b0;
    commit_br_cnt = '0; mispredict = 1'b0; mispred_keep = '0;
    jmp_tgt_valid = 1'b0; jmp_tgt = '0;
    repeat (2) @(posedge clk);
    m_mode = 0; m_cnt = 0; m_flush = 0;

    // Reset state
    idle(0, 0, 0, 0, 0, 0);
    chk("rst_cnt", br_cnt, 0); chk("rst_wait", wait_jmp, 0); chk("rst_flush", flush_mem, 0);
    tick();

    // Two not-taken branches fill the window
    apply(0, 16'h0100, grp4(ADD, BR, ADD, BR), 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("tp1_valid", slot_valid, 4'b1111); chk("tp1_upd", update_bpred, 1);
    tick();
    idle(1, 0, 0, 0, 0, 0);
    chk("tp1_cnt", br_cnt, 2); chk("tp1_full", brch_full, 1);
    tick();

    // Cap truncation at slot 1 with one branch in flight
    apply(0, 16'h0100, grp4(BR, BR, ADD, ADD), 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("tp2_valid", slot_valid, 4'b0001); chk("tp2_pcsel", pcsel_from_bhndlr, 1);
    chk("tp2_pc", pc_bhndlr, 16'h0101);
    tick();
    idle(0, 0, 0, 0, 0, 0);
    chk("tp2_cnt", br_cnt, 2);
    tick();

    // Mispredict overrides a same-cycle commit
    idle(1, 1, 0, 0, 0, 0);
    tick();
    idle(0, 0, 0, 0, 0, 0);
    chk("tp5_cnt", br_cnt, 0); chk("tp5_flushvalid", slot_valid, 4'b0000);
    chk("tp5_pcsel", pcsel_from_bhndlr, 0);
    tick();
    idle(0, 0, 0, 0, 0, 0);
    chk("tp5_run", slot_valid, 4'b1111);
    tick();

    // Register jump waits for its target
    apply(0, 16'h0100, grp4(ADD, REGJ, ADD, ADD), 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("tp3_valid", slot_valid, 4'b0011);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(0, 0, 0, 0, 16'h0200, 0);
      chk("tp3_wait", wait_jmp, 1); chk("tp3_hold", pc_bhndlr, 16'h0100);
      tick();
    end
    idle(0, 0, 0, 1, 16'h0200, 0);
    chk("tp3_tgt", pc_bhndlr, 16'h0200); chk("tp3_tgtsel", pcsel_from_bhndlr, 1);
    tick();
    idle(0, 0, 0, 0, 0, 0);
    chk("tp3_run", wait_jmp, 0);
    tick();

    // Predicted-taken branch in slot 0
    apply(0, 16'h0100, grp4(BR, ADD, IMJ, ADD), 4'b0001, 0, 0, 0, 0, 0, 0);
    chk("tp4_valid", slot_valid, 4'b0001); chk("tp4_tkn", tkn_brnch, 4'b0001);
    chk("tp4_pcsel", pcsel_from_bhndlr, 0);
    tick();
    idle(0, 0, 0, 0, 0, 0);
    chk("tp4_flush", flush_mem, 1);
    tick();

    // Reset while waiting on a register jump with a full window
    apply(0, 16'h0100, grp4(BR, REGJ, ADD, ADD), 4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0, 0, 0, 0, 0, 1);
    chk("tp6_pre_wait", wait_jmp, 1); chk("tp6_pre_cnt", br_cnt, 2);
    tick();
    idle(0, 0, 0, 0, 0, 0);
    chk("tp6_wait", wait_jmp, 0); chk("tp6_cnt", br_cnt, 0); chk("tp6_flush", flush_mem, 0);
    tick();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      apply(($urandom_range(0, 63) == 0),
            16'($urandom),
            grp4(rand_inst(), rand_inst(), rand_inst(), rand_inst()),
            4'($urandom),
            ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0),
            16'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
